// File: rtl/grid_lock_clear.sv
// ---------------------------------------------------------------------------------------------
// grid_lock_clear
//   Writer side of the playfield. Owns the registered occupancy grid. On a lock request it ORs
//   the landed piece's 12-bit neighbour pattern into the grid at the anchor cell, then scans
//   rows bottom-up, removes full lines (shifting the rows above down) and reports the number of
//   lines removed plus a saturating running total.
//
//   Cell index = row*COLS + col, row 0 is the top (spawn) row.
//
//   Ports
//     clk             system clock
//     rst             asynchronous reset, active-high
//     lock_start      1-cycle pulse: merge piece and clear lines
//     blockNeighbors  piece cell pattern (same bit/offset map as the collision checks)
//     gridNum         anchor cell index of the piece
//     grid_clr        synchronous clear of grid and line total (new game)
//     grid            registered playfield, 1 = occupied
//     busy            high from the cycle after lock_start until the sequence completes
//     done            1-cycle pulse when the lock sequence completes
//     lines_cleared   lines removed by the last lock (0..4), valid with done
//     lines_total     saturating total of lines since reset / grid_clr
//     score           (only with GRID_SCORE_EN) saturating score, 0/40/100/300/1200 per lock
//
//   Build option: define GRID_SCORE_EN to add the score output and its accumulator.
// ---------------------------------------------------------------------------------------------
module grid_lock_clear #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lock_start,
    input  logic [11:0]          blockNeighbors,
    input  logic [9:0]           gridNum,
    input  logic                 grid_clr,
    output logic [COLS*ROWS-1:0] grid,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_cleared,
    output logic [15:0]          lines_total
`ifdef GRID_SCORE_EN
    ,
    output logic [19:0]          score
`endif
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int          C     = int'(COLS);

    typedef enum logic [2:0] {
        StIdle,
        StMerge,
        StScan,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CELLS-1:0] grid_q, grid_d;
    logic [11:0]      pat_q, pat_d;
    logic [9:0]       anchor_q, anchor_d;
    logic [RW-1:0]    row_q, row_d;
    logic [2:0]       count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       lc_q, lc_d;
    logic [15:0]      total_q, total_d;

    logic [CELLS-1:0] merge_mask;
    logic [CELLS-1:0] grid_shift;
    logic             row_full;
    logic [16:0]      total_sum;
    logic [15:0]      total_sat;

`ifdef GRID_SCORE_EN
    logic [19:0] score_q, score_d;
    logic [20:0] score_sum;
    logic [19:0] score_sat;

    function automatic logic [19:0] line_points(input logic [2:0] n);
        case (n)
            3'd1:    line_points = 20'd40;
            3'd2:    line_points = 20'd100;
            3'd3:    line_points = 20'd300;
            3'd4:    line_points = 20'd1200;
            default: line_points = 20'd0;
        endcase
    endfunction
`endif

    // Offset of each pattern bit relative to the anchor cell.
    function automatic int cell_off(input int b);
        case (b)
            11:      cell_off = 3 * C;
            10:      cell_off = 2 * C + 1;
            9:       cell_off = 2 * C;
            8:       cell_off = 2 * C - 1;
            7:       cell_off = C + 1;
            6:       cell_off = C;
            5:       cell_off = C - 1;
            4:       cell_off = 3;
            3:       cell_off = 2;
            2:       cell_off = 1;
            1:       cell_off = 0;
            default: cell_off = -1;
        endcase
    endfunction

    // Piece cells that fall inside the playfield; anything outside is silently dropped.
    always_comb begin
        int tgt;
        tgt        = 0;
        merge_mask = '0;
        for (int b = 0; b < 12; b++) begin
            if (pat_q[b]) begin
                tgt = int'({22'd0, anchor_q}) + cell_off(b);
                if (tgt >= 0 && tgt < int'(CELLS)) begin
                    merge_mask[tgt[IW-1:0]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (int'(row_q) == r) begin
                row_full = &grid_q[r*C +: COLS];
            end
        end
    end

    // Rows 1..row_q drop by one, row 0 empties, rows below row_q are untouched.
    always_comb begin
        grid_shift          = grid_q;
        grid_shift[C-1:0]   = '0;
        for (int r = 1; r < int'(ROWS); r++) begin
            if (r <= int'(row_q)) begin
                grid_shift[r*C +: COLS] = grid_q[(r-1)*C +: COLS];
            end
        end
    end

    assign total_sum = {1'b0, total_q} + {14'd0, count_q};
    assign total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];

`ifdef GRID_SCORE_EN
    assign score_sum = {1'b0, score_q} + {1'b0, line_points(count_q)};
    assign score_sat = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
`endif

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        pat_d    = pat_q;
        anchor_d = anchor_q;
        row_d    = row_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lc_d     = lc_q;
        total_d  = total_q;
`ifdef GRID_SCORE_EN
        score_d  = score_q;
`endif

        case (state_q)
            StIdle: begin
                if (lock_start) begin
                    pat_d    = blockNeighbors;
                    anchor_d = gridNum;
                    busy_d   = 1'b1;
                    state_d  = StMerge;
                end
            end
            StMerge: begin
                grid_d  = grid_q | merge_mask;
                row_d   = RW'(ROWS - 1);
                count_d = 3'd0;
                state_d = StScan;
            end
            StScan: begin
                if (row_full) begin
                    state_d = StShift;
                end else if (row_q == '0) begin
                    // Outputs are registered here so they are valid during the DONE cycle.
                    done_d  = 1'b1;
                    lc_d    = count_q;
                    total_d = total_sat;
`ifdef GRID_SCORE_EN
                    score_d = score_sat;
`endif
                    state_d = StDone;
                end else begin
                    row_d = row_q - 1'b1;
                end
            end
            StShift: begin
                // Same row is rescanned so stacked full lines are caught.
                grid_d  = grid_shift;
                count_d = count_q + 3'd1;
                state_d = StScan;
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        if (grid_clr) begin
            state_d = StIdle;
            grid_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            lc_d    = 3'd0;
            total_d = 16'd0;
`ifdef GRID_SCORE_EN
            score_d = 20'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grid_q   <= '0;
            pat_q    <= '0;
            anchor_q <= '0;
            row_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lc_q     <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            pat_q    <= pat_d;
            anchor_q <= anchor_d;
            row_q    <= row_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lc_q     <= lc_d;
            total_q  <= total_d;
        end
    end

`ifdef GRID_SCORE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`endif

    assign grid          = grid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lc_q;
    assign lines_total   = total_q;

endmodule
